// File: rtl/axis_wr_arb.sv
// axis_wr_arb: round-robin arbiter that shares one AXI-Stream write-master port
// between N_REQ requesters. Each beat is {addr, data}. A grant covers one
// tlast-delimited packet or at most QUOTA beats, whichever ends first. The
// output goes through a single register stage that keeps full throughput.
// Optional feature macro: AXIS_WR_ARB_STATS_EN adds per-requester 32-bit
// accepted-beat counters on beat_cnt. When the macro is not defined,
// beat_cnt is tied to 0 and clr_stats is ignored.
module axis_wr_arb #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int QUOTA      = 8
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [N_REQ-1:0]                          s_axis_tvalid,
  output logic [N_REQ-1:0]                          s_axis_tready,
  input  logic [N_REQ*(DATA_WIDTH+ADDR_WIDTH)-1:0]  s_axis_tdata,
  input  logic [N_REQ-1:0]                          s_axis_tlast,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0]          m_axis_tdata,
  output logic                                      m_axis_tlast,
  output logic [N_REQ-1:0]                          grant,
  output logic                                      busy,
  input  logic                                      clr_stats,
  output logic [N_REQ*32-1:0]                       beat_cnt
);

  localparam int BEAT_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(QUOTA) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUOTA - 1);

  typedef enum logic {IDLE_ST, GRANT_ST} state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;      // last winner, search starts after it
  logic [PTR_W-1:0]    owner_q;    // index of current grant holder
  logic [N_REQ-1:0]    grant_q;
  logic [CNT_W-1:0]    cnt_q;      // beats accepted in the current grant
  logic                m_valid_q;
  logic                m_last_q;
  logic [BEAT_W-1:0]   m_data_q;

  logic                win_found_d;
  logic [PTR_W-1:0]    win_idx_d;
  logic [BEAT_W-1:0]   sel_beat;
  logic                sel_last;
  logic                out_free;
  logic                accept;

  // Rotating search: first valid requester after the previous winner.
  always_comb begin
    logic [PTR_W-1:0] cand;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!win_found_d && s_axis_tvalid[cand]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand;
      end
    end
  end

  assign sel_beat = s_axis_tdata[int'(owner_q)*BEAT_W +: BEAT_W];
  assign sel_last = s_axis_tlast[owner_q];
  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = ~m_valid_q | m_axis_tready;
  assign accept   = (state_q == GRANT_ST) & s_axis_tvalid[owner_q] & out_free;

  // Only the owner sees ready, and only while the output stage can take a beat.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == GRANT_ST) begin
      s_axis_tready[owner_q] = out_free;
    end
  end

  // Arbitration FSM plus output register; a drain and a load in the same cycle keep valid high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE_ST;
      ptr_q     <= PTR_W'(N_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= sel_beat;
        m_last_q  <= sel_last;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE_ST: begin
          if (win_found_d) begin
            grant_q <= N_REQ'(1) << win_idx_d;
            owner_q <= win_idx_d;
            ptr_q   <= win_idx_d;
            cnt_q   <= '0;
            state_q <= GRANT_ST;
          end
        end
        GRANT_ST: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            // A quota cut leaves tlast as forwarded; the packet resumes on the next grant.
            if (sel_last || (cnt_q == CNT_LAST)) begin
              state_q <= IDLE_ST;
              grant_q <= '0;
            end
          end
        end
        default: state_q <= IDLE_ST;
      endcase
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign grant         = grant_q;
  assign busy          = (state_q == GRANT_ST) | m_valid_q;

`ifdef AXIS_WR_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [31:0] stat_q;
      // Accepted-beat counter for requester gi; clear has priority over increment.
      always_ff @(posedge clk) begin
        if (!rstn || clr_stats) begin
          stat_q <= '0;
        end else if (s_axis_tvalid[gi] && s_axis_tready[gi]) begin
          stat_q <= stat_q + 32'd1;
        end
      end
      assign beat_cnt[gi*32 +: 32] = stat_q;
    end
  endgenerate
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign beat_cnt         = '0;
`endif

endmodule

// File: tb/tb_axis_wr_arb.sv
// tb_axis_wr_arb: directed stimulus with a scoreboard for axis_wr_arb.
// Source queues model the requesters. Expected output beats are queued when
// stimulus is issued. A negedge monitor pops each expected beat and compares
// it on every output handshake. It also checks that the output holds steady
// during stalls.
`timescale 1ns/1ps
module tb_axis_wr_arb;
  localparam int N_REQ = 2;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int QUOTA = 8;
  localparam int BW    = DW + AW;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [N_REQ-1:0]    s_axis_tvalid = '0;
  logic [N_REQ-1:0]    s_axis_tready;
  logic [N_REQ*BW-1:0] s_axis_tdata = '0;
  logic [N_REQ-1:0]    s_axis_tlast = '0;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b1;
  logic [BW-1:0]       m_axis_tdata;
  logic                m_axis_tlast;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic                clr_stats = 1'b0;
  logic [N_REQ*32-1:0] beat_cnt;

  axis_wr_arb #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUOTA(QUOTA)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .grant(grant), .busy(busy), .clr_stats(clr_stats), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  logic  rdy_toggle = 1'b0;
  logic  rdy_fix = 1'b1;
  logic [N_REQ-1:0] hs;
  beat_t mon_e;
  logic  hold_v = 1'b0;
  beat_t hold_b;

  function automatic logic [BW-1:0] mk(int r, int i);
    logic [31:0] a;
    logic [63:0] d;
    a = 32'h1000_0000 + 32'(r) * 32'h0001_0000 + 32'(i) * 32'd8;
    d = 64'hD0D0_0000_0000_0000 + 64'(r) * 64'h100 + 64'(i);
    return {a, d};
  endfunction

  function automatic logic is_last(int i, int every);
    return (every > 0) && ((i % every) == every - 1);
  endfunction

  task automatic load(int r, int n, int every);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = mk(r, i);
      b.l = is_last(i, every);
      if (r == 0) src0_q.push_back(b);
      else        src1_q.push_back(b);
    end
  endtask

  task automatic exp_beats(int r, int lo, int hi, int every);
    beat_t b;
    for (int i = lo; i <= hi; i++) begin
      b.d = mk(r, i);
      b.l = is_last(i, every);
      exp_q.push_back(b);
    end
  endtask

  task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive();
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    if (src0_q.size() > 0) begin
      s_axis_tvalid[0]     = 1'b1;
      s_axis_tdata[BW-1:0] = src0_q[0].d;
      s_axis_tlast[0]      = src0_q[0].l;
    end
    if (src1_q.size() > 0) begin
      s_axis_tvalid[1]        = 1'b1;
      s_axis_tdata[2*BW-1:BW] = src1_q[0].d;
      s_axis_tlast[1]         = src1_q[0].l;
    end
    m_axis_tready = rdy_toggle ? ~cyc[0] : rdy_fix;
  endtask

  task automatic step();
    beat_t dummy;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs[0] && src0_q.size() > 0) dummy = src0_q.pop_front();
    if (hs[1] && src1_q.size() > 0) dummy = src1_q.pop_front();
    drive();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    clr_stats  = 1'b0;
    rdy_toggle = 1'b0;
    rdy_fix    = 1'b1;
    drive();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic drain(string name, int max);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || src0_q.size() > 0 || src1_q.size() > 0) && k < max) begin
      step();
      k++;
    end
    step();
    step();
    chk({name, "_leftover"}, BW'(exp_q.size() + src0_q.size() + src1_q.size()), '0);
  endtask

  // Scoreboard monitor: one comparison per output handshake, plus stall stability.
  always @(negedge clk) begin
    if (rstn && hold_v && m_axis_tvalid) begin
      n_cmp++;
      if (m_axis_tdata !== hold_b.d || m_axis_tlast !== hold_b.l) begin
        n_err++;
        $display("FAIL stall_hold: got %0h/%0b, want %0h/%0b", m_axis_tdata, m_axis_tlast, hold_b.d, hold_b.l);
      end
    end
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got %0h/%0b, want none", m_axis_tdata, m_axis_tlast);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_axis_tdata !== mon_e.d || m_axis_tlast !== mon_e.l) begin
          n_err++;
          $display("FAIL beat: got %0h/%0b, want %0h/%0b", m_axis_tdata, m_axis_tlast, mon_e.d, mon_e.l);
        end else begin
          $display("beat %0h last=%0b", m_axis_tdata, m_axis_tlast);
        end
      end
    end
    hold_v   = rstn && m_axis_tvalid && !m_axis_tready;
    hold_b.d = m_axis_tdata;
    hold_b.l = m_axis_tlast;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_m_tvalid", BW'(m_axis_tvalid), '0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tlast", BW'(m_axis_tlast), '0);
    chk("rst_s_tready", BW'(s_axis_tready), '0);
    chk("rst_grant", BW'(grant), '0);
    chk("rst_busy", BW'(busy), '0);

    // 4-beat packet from req0 at full rate
    load(0, 4, 4);
    exp_beats(0, 0, 3, 4);
    drive();
    for (int s = 1; s <= 6; s++) begin
      step();
      chk($sformatf("pkt4_grant_c%0d", s), BW'(grant), (s <= 4) ? BW'(2'b01) : BW'(2'b00));
      if (s == 5) chk("pkt4_busy_c5", BW'(busy), BW'(1'b1));
      if (s == 6) chk("pkt4_busy_c6", BW'(busy), BW'(1'b0));
    end
    drain("pkt4", 20);

    // Two continuous requesters, no tlast: alternating quota-limited grants
    do_reset();
    load(0, 16, 0);
    load(1, 16, 0);
    exp_beats(0, 0, 7, 0);
    exp_beats(1, 0, 7, 0);
    exp_beats(0, 8, 15, 0);
    exp_beats(1, 8, 15, 0);
    drive();
    step();
    chk("quota_grant_c1", BW'(grant), BW'(2'b01));
    for (int s = 2; s <= 10; s++) begin
      step();
      if (s == 9)  chk("quota_grant_c9", BW'(grant), BW'(2'b00));
      if (s == 10) chk("quota_grant_c10", BW'(grant), BW'(2'b10));
    end
    drain("quota", 200);

    // Output backpressure toggling 1010
    do_reset();
    rdy_toggle = 1'b1;
    load(0, 6, 6);
    exp_beats(0, 0, 5, 6);
    drive();
    drain("stall", 100);

    // Only req1 valid after reset, single-beat packets: one beat every two cycles
    do_reset();
    load(1, 3, 1);
    exp_beats(1, 0, 2, 1);
    drive();
    step();
    chk("solo_grant_c1", BW'(grant), BW'(2'b10));
    for (int s = 2; s <= 6; s++) begin
      step();
      if (s == 5) chk("solo_left_c5", BW'(src1_q.size()), BW'(1));
      if (s == 6) chk("solo_left_c6", BW'(src1_q.size()), BW'(0));
    end
    drain("solo", 20);

    // Reset asserted in cycle 3 of a grant
    do_reset();
    load(0, 10, 0);
    exp_beats(0, 0, 0, 0);
    drive();
    step();
    step();
    step();
    chk("midrst_grant_pre", BW'(grant), BW'(2'b01));
    chk("midrst_valid_pre", BW'(m_axis_tvalid), BW'(1'b1));
    rstn    = 1'b0;
    rdy_fix = 1'b0;
    drive();
    step();
    chk("midrst_m_tvalid", BW'(m_axis_tvalid), '0);
    chk("midrst_grant", BW'(grant), '0);
    chk("midrst_s_tready", BW'(s_axis_tready), '0);
    chk("midrst_exp_left", BW'(exp_q.size()), '0);

    // Mixed traffic: 20 beats req0 (packets of 4), 12 beats req1 (one packet)
    do_reset();
    load(0, 20, 4);
    load(1, 12, 12);
    exp_beats(0, 0, 3, 4);
    exp_beats(1, 0, 7, 12);
    exp_beats(0, 4, 7, 4);
    exp_beats(1, 8, 11, 12);
    exp_beats(0, 8, 19, 4);
    drive();
    drain("mixed", 300);
`ifdef AXIS_WR_ARB_STATS_EN
    chk("stats_cnt0", BW'(beat_cnt[31:0]), BW'(20));
    chk("stats_cnt1", BW'(beat_cnt[63:32]), BW'(12));
`else
    chk("stats_off_cnt", BW'(beat_cnt), '0);
`endif

    // clr_stats held across an accepted beat
    load(0, 1, 1);
    exp_beats(0, 0, 0, 1);
    clr_stats = 1'b1;
    drive();
    step();
    step();
    clr_stats = 1'b0;
    drive();
    step();
    chk("clr_cnt", BW'(beat_cnt), '0);
    drain("clr", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
